ifu_prefetch: RTL

Parametrised instruction fetch unit with an internal instruction memory and a FIFO prefetch queue. It replaces the single-register IFU of the multi-cycle core. It fetches sequentially ahead of decode, delivers instructions over a valid/ready handshake, and takes redirects from execute: register jump, j-jump and beq-jump, using the same next-PC rules as the current IFU. Any redirect flushes all prefetched and in-flight instructions.

---
 rtl/ifu_prefetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with an internal instruction memory and a
// circular prefetch queue. It fetches sequentially ahead of decode, hands
// instructions over a valid/ready handshake, and takes reg/j/beq redirects from
// execute. A redirect flushes both the queue and the in-flight memory read.
module ifu_prefetch #(
  parameter logic [31:0] CODE_SEG_PC = 32'h0000_3000,
  parameter int          IM_WORDS    = 1024,
  parameter int          FQ_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [1:0]                redirect_sel,
  input  logic [31:0]               regPC,
  input  logic [31:0]               redirect_pc,
  input  logic [31:0]               redirect_instr,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int AW = $clog2(IM_WORDS);   // memory word-index width
  localparam int QW = $clog2(FQ_DEPTH);   // queue pointer width
  localparam int CW = QW + 1;             // queue occupancy width

  // Redirect kinds as encoded by execute.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_REG  = 2'b01;
  localparam logic [1:0] SEL_J    = 2'b10;
  localparam logic [1:0] SEL_BEQ  = 2'b11;

  // Occupancy limit at the width of the issue-check arithmetic.
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FQ_DEPTH);

  // Instruction memory; contents are loaded from outside the design.
  logic [31:0] im [IM_WORDS];

  // Fetch pointer and one-stage read pipe.
  logic [31:0] fetch_pc;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_data;

  // Prefetch queue storage and pointers.
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [CW-1:0] count;

  // Per-cycle control.
  logic          pop;
  logic          push;
  logic          redirect;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [31:0]   im_offs;
  logic [AW-1:0] im_idx;
  logic [31:0]   pc_plus4;
  logic [31:0]   beq_offset;
  logic [31:0]   redirect_target;

  // Handshake and queue accounting. Pop only happens when the head is valid,
  // so occupancy cannot underflow.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = rd_valid;
  assign redirect  = redirect_valid && (redirect_sel != SEL_NONE);
  assign occupancy = {1'b0, count} + (CW + 1)'(rd_valid) - (CW + 1)'(pop);
  // The in-flight read is counted so a returning word always finds a free slot.
  assign issue     = (occupancy < DEPTH_LIM) && !redirect;

  // Word index into the memory; the offset wraps modulo IM_WORDS.
  assign im_offs = fetch_pc - CODE_SEG_PC;
  assign im_idx  = im_offs[AW+1:2];

  // Redirect target arithmetic shared with the old single-register IFU.
  assign pc_plus4   = redirect_pc + 32'd4;
  assign beq_offset = {{14{redirect_instr[15]}}, redirect_instr[15:0], 2'b00};

  // Select the redirect target for the requested jump kind.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    redirect_target = fetch_pc;
    case (redirect_sel)
      SEL_REG: redirect_target = {regPC[31:2], 2'b00};
      SEL_J:   redirect_target = {pc_plus4[31:28], redirect_instr[25:0], 2'b00};
      SEL_BEQ: redirect_target = pc_plus4 + beq_offset;
      default: redirect_target = fetch_pc;
    endcase
  end

  // Fetch pointer, read-pipe valid and queue pointers; redirect outranks all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values of its neighbours.
      fetch_pc <= CODE_SEG_PC;
      rd_valid <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      rd_valid <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      rd_valid <= issue;
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Synchronous memory read and its PC tag; qualified by rd_valid downstream.
  always_ff @(posedge clk) begin
    // NOTE: memories and pure data paths carry no reset; the valid bits and
    // queue count decide whether their contents mean anything.
    if (issue) begin
      rd_data <= im[im_idx];
      rd_pc   <= fetch_pc;
    end
  end

  // Write the returning word into the queue tail unless a redirect kills it.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      q_pc[tail]    <= rd_pc;
      q_instr[tail] <= rd_data;
    end
  end

  // Head entry is presented from registers; zeros while the queue is empty.
  assign out_pc    = out_valid ? q_pc[head]    : 32'd0;
  assign out_instr = out_valid ? q_instr[head] : 32'd0;
  assign fq_count  = count;

  // Bits that the fetch and redirect arithmetic deliberately ignore.
  logic unused_bits;
  assign unused_bits = ^{redirect_instr[31:26], regPC[1:0],
                         im_offs[31:AW+2], im_offs[1:0]};

endmodule
